nlm_fold_acc: RTL
=================

NLM_FOLD_ACC -- requirements
Module: nlm_fold_acc

Interface
REQ-001 SHALL have parameter SRH_LENGTH, default 13, full search length; WIN = ((SRH_LENGTH+1)/2)^2 candidate positions (49).
REQ-002 SHALL have parameter DATA_WIDTH, default 12, pixel width.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8, unsigned weight width.
REQ-004 SHALL have parameter LANES, default 7, positions accepted per beat; legal range 1..WIN.
REQ-005 SHALL have parameter CENTER_MODE, default 0: 0 = center weight used as supplied; 1 = center weight replaced by max non-center weight.
REQ-006 SHALL derive WSW = WEIGHT_WIDTH + $clog2(WIN) (14), PSW = WSW + DATA_WIDTH (26), BEATS = ceil(WIN/LANES) (7), CENTER = (WIN-1)/2 (24).
REQ-007 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-009 SHALL have port clr_i, input, 1, synchronous abort of the current window.
REQ-010 SHALL have port in_valid_i, input, 1, beat valid.
REQ-011 SHALL have port in_ready_o, output, 1, beat accepted when valid and ready are both high.
REQ-012 SHALL have port weight_i, input, LANES*WEIGHT_WIDTH, lane l at bits [l*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-013 SHALL have port pix_i, input, LANES*DATA_WIDTH, lane l at bits [l*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port out_valid_o, output, 1, result valid.
REQ-015 SHALL have port out_ready_i, input, 1, result consumed when valid and ready are both high.
REQ-016 SHALL have port weight_sum_o, output, WSW, window weight sum.
REQ-017 SHALL have port pix_sum_o, output, PSW, window sum of weight*pixel.

Function
REQ-018 SHALL run FSM IDLE, ACC, CTR, OUT; IDLE->ACC on first accepted beat; ACC->CTR on last beat when CENTER_MODE=1, else ACC->OUT; CTR->OUT after one cycle; OUT->IDLE on output handshake.
REQ-019 SHALL map beat b, lane l to position p = b*LANES + l; SHALL mask lanes with p >= WIN (contribute zero).
REQ-020 SHALL keep a beat counter 0..BEATS-1, wrapping to 0 on the last beat.
REQ-021 SHALL, per accepted beat, add the sum of unmasked lane weights to the weight accumulator and the sum of weight*pixel products to the pixel accumulator in the same cycle (single-cycle adder tree, no internal overflow at max inputs).
REQ-022 SHALL, when CENTER_MODE=1, exclude position CENTER from both accumulators, register its pixel, and track the running max of the other weights.
REQ-023 SHALL, in CTR, add max_w to weight_sum and max_w*center_pix to pix_sum.
REQ-024 SHALL drive in_ready_o high only in IDLE and ACC.
REQ-025 SHALL assert out_valid_o one cycle after the last beat is accepted (CENTER_MODE=0) or two cycles after (CENTER_MODE=1).
REQ-026 SHALL hold out_valid_o, weight_sum_o and pix_sum_o stable while out_ready_i is low.
REQ-027 SHALL clear accumulators and the max register on entry to ACC, so back-to-back windows do not mix.
REQ-028 SHALL, on clr_i, return to IDLE with counter, accumulators and out_valid_o cleared next cycle; clr_i has priority over all handshakes.
REQ-029 SHALL treat in_valid_i as ignored while in_ready_o is low.

Reset
REQ-030 SHALL, on rst_n low, force state IDLE, beat counter 0, accumulators 0, max 0, out_valid_o 0, weight_sum_o 0, pix_sum_o 0, and in_ready_o 1 after release.
REQ-031 SHALL, on reset mid-window, discard partial sums; the next accepted beat is beat 0.

Structure
REQ-032 SHALL place WEIGHT_WIDTH default, derived-width functions (WIN, WSW, PSW, BEATS) and FSM state encoding in a shared package nlm_pkg.
REQ-033 SHALL use one sub-module, nlm_lane_tree: combinational masked weight sum and product sum of one beat.

Verification
REQ-034 SHALL test defaults, all weights 1, all pixels 100, 7 back-to-back beats -> weight_sum 49, pix_sum 4900, out_valid 1 cycle after beat 7.
REQ-035 SHALL test weights 255 and pixels 4095 everywhere -> weight_sum 12495, pix_sum 51167025 (no overflow).
REQ-036 SHALL test CENTER_MODE=1 with weights 1 except center (beat 3, lane 3) weight 255, pixel 4000, other pixels 0 -> weight_sum 49, pix_sum 4000, out_valid 2 cycles after last beat.
REQ-037 SHALL test LANES=10 (5 beats) with weight 255 / pixel 4095 only on beat 4 lanes 9 and all else 0 -> weight_sum 0, pix_sum 0 (masked lane).
REQ-038 SHALL test out_ready low 5 cycles after result -> outputs stable, in_ready low; handshake then returns to IDLE, and the next window is correct.
REQ-039 SHALL test clr_i or rst_n low after beat 3, then a full all-ones window -> weight_sum 49 (no residue).

Source files
------------

// File: rtl/nlm_pkg.sv
// Shared sizing helpers and FSM state encoding for the NLM fold accumulator.
package nlm_pkg;

   localparam int WEIGHT_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_CTR  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   function automatic int calc_win(input int srh);
      return ((srh + 1) / 2) * ((srh + 1) / 2);
   endfunction

   function automatic int calc_wsw(input int ww, input int win);
      return ww + $clog2(win);
   endfunction

   function automatic int calc_psw(input int wsw, input int dw);
      return wsw + dw;
   endfunction

   function automatic int calc_beats(input int win, input int lanes);
      return (win + lanes - 1) / lanes;
   endfunction

   function automatic int calc_cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nlm_lane_tree.sv
// One beat: masked weight sum, weight*pixel sum, max weight and center capture.
module nlm_lane_tree
   import nlm_pkg::*;
#(
   parameter int LANES        = 7,
   parameter int DATA_WIDTH   = 12,
   parameter int WEIGHT_WIDTH = 8,
   parameter int WIN          = 49,
   parameter int WSW          = 14,
   parameter int PSW          = 26,
   parameter int CENTER_MODE  = 0,
   parameter int CENTER       = 24,
   parameter int BCW          = 3
) (
   input  logic [BCW-1:0]                beat,
   input  logic [LANES*WEIGHT_WIDTH-1:0] weight,
   input  logic [LANES*DATA_WIDTH-1:0]   pix,
   output logic [WSW-1:0]                wsum,
   output logic [PSW-1:0]                psum,
   output logic [WEIGHT_WIDTH-1:0]       wmax,
   output logic                          center_hit,
   output logic [DATA_WIDTH-1:0]         center_pix
);

   int p;

   always_comb begin
      wsum       = '0;
      psum       = '0;
      wmax       = '0;
      center_hit = 1'b0;
      center_pix = '0;
      p          = 0;
      for (int l = 0; l < LANES; l++) begin
         p = int'(beat) * LANES + l;
         // positions past the end of the window only exist on the final beat
         if (p < WIN) begin
            if (CENTER_MODE != 0 && p == CENTER) begin
               center_hit = 1'b1;
               center_pix = pix[l*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               wsum = wsum + WSW'(weight[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
               psum = psum + PSW'(weight[l*WEIGHT_WIDTH +: WEIGHT_WIDTH])
                           * PSW'(pix[l*DATA_WIDTH +: DATA_WIDTH]);
               if (weight[l*WEIGHT_WIDTH +: WEIGHT_WIDTH] > wmax)
                  wmax = weight[l*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/nlm_fold_acc.sv
// Folds one NLM search window, LANES positions per beat, into weight and pixel sums.
//   state  | meaning
//   S_IDLE | waiting for beat 0 of a window
//   S_ACC  | accumulating beats 1..BEATS-1
//   S_CTR  | adding max non-center weight for the center position (CENTER_MODE=1)
//   S_OUT  | result held until out_ready_i
module nlm_fold_acc
   import nlm_pkg::*;
#(
   parameter int SRH_LENGTH   = 13,
   parameter int DATA_WIDTH   = 12,
   parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
   parameter int LANES        = 7,
   parameter int CENTER_MODE  = 0,
   localparam int WIN    = calc_win(SRH_LENGTH),
   localparam int WSW    = calc_wsw(WEIGHT_WIDTH, WIN),
   localparam int PSW    = calc_psw(WSW, DATA_WIDTH),
   localparam int BEATS  = calc_beats(WIN, LANES),
   localparam int CENTER = (WIN - 1) / 2,
   localparam int BCW    = calc_cw(BEATS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [LANES*WEIGHT_WIDTH-1:0] weight_i,
   input  logic [LANES*DATA_WIDTH-1:0]   pix_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [WSW-1:0]                weight_sum_o,
   output logic [PSW-1:0]                pix_sum_o
);

   state_t                  state, state_n;
   logic [BCW-1:0]          beat_cnt;
   logic [WSW-1:0]          acc_w, beat_w;
   logic [PSW-1:0]          acc_p, beat_p;
   logic [WEIGHT_WIDTH-1:0] max_w, beat_max;
   logic [DATA_WIDTH-1:0]   cpix, beat_cpix;
   logic                    beat_chit;
   logic                    accept, last_beat;

   assign in_ready_o   = (state == S_IDLE) || (state == S_ACC);
   assign out_valid_o  = (state == S_OUT);
   assign accept       = in_valid_i && in_ready_o;
   assign last_beat    = (beat_cnt == BCW'(BEATS - 1));
   assign weight_sum_o = acc_w;
   assign pix_sum_o    = acc_p;

   nlm_lane_tree #(
      .LANES(LANES), .DATA_WIDTH(DATA_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .WIN(WIN), .WSW(WSW), .PSW(PSW), .CENTER_MODE(CENTER_MODE),
      .CENTER(CENTER), .BCW(BCW)
   ) u_tree (
      .beat(beat_cnt), .weight(weight_i), .pix(pix_i),
      .wsum(beat_w), .psum(beat_p), .wmax(beat_max),
      .center_hit(beat_chit), .center_pix(beat_cpix)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_ACC: begin
            if (accept && last_beat)
               state_n = (CENTER_MODE != 0) ? S_CTR : S_OUT;
            else if (accept)
               state_n = S_ACC;
         end
         S_CTR:   state_n = S_OUT;
         S_OUT:   if (out_ready_i) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (clr_i) state_n = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         acc_w    <= '0;
         acc_p    <= '0;
         max_w    <= '0;
         cpix     <= '0;
      end else if (clr_i) begin
         beat_cnt <= '0;
         acc_w    <= '0;
         acc_p    <= '0;
         max_w    <= '0;
      end else if (accept) begin
         beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
         // the first beat overwrites, which clears anything left from the previous window
         if (state == S_IDLE) begin
            acc_w <= beat_w;
            acc_p <= beat_p;
            max_w <= beat_max;
         end else begin
            acc_w <= acc_w + beat_w;
            acc_p <= acc_p + beat_p;
            if (beat_max > max_w) max_w <= beat_max;
         end
         if (beat_chit) cpix <= beat_cpix;
      end else if (state == S_CTR) begin
         acc_w <= acc_w + WSW'(max_w);
         acc_p <= acc_p + PSW'(max_w) * PSW'(cpix);
      end
   end

endmodule
